// File: rtl/ex_lead_count.sv
// Iterative CLZ/CLO unit for the EX stage: scans STEP bits per cycle from the MSB,
// stops at the first one bit, and holds the count until the pipeline drops start_i.
module ex_lead_count #(
   parameter int STEP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        op_i,
   input  logic [31:0] data_i,
   input  logic        annul_i,
   output logic [31:0] result_o,
   output logic        ready_o,
   output logic        stallreq_o,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_sh;
   logic [5:0]  r_cnt;
   logic [5:0]  r_result;
   logic [STEP-1:0] w_win;
   logic [5:0]  w_lz;
   logic [5:0]  w_cnt_step;
   logic        w_scan_end;
   logic        w_found;

   assign w_win      = r_sh[31 -: STEP];
   assign w_cnt_step = r_cnt + 6'(STEP);

   // Leading zeros of the current window; an all-zero window counts as STEP.
   always_comb begin
      w_lz    = 6'(STEP);
      w_found = 1'b0;
      for (int i = STEP - 1; i >= 0; i--) begin
         if (!w_found && w_win[i]) begin
            w_lz    = 6'(STEP - 1 - i);
            w_found = 1'b1;
         end
      end
   end

   assign w_scan_end = w_found || (w_cnt_step >= 6'd32);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Next-state logic; annul_i wins over start_i and scan completion
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start_i && !annul_i) w_next = S_SCAN;
         S_SCAN: begin
            if (annul_i)         w_next = S_IDLE;
            else if (w_scan_end) w_next = S_DONE;
         end
         S_DONE: if (annul_i || !start_i) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      stallreq_o = 1'b0;
      case (r_state)
         S_IDLE:  stallreq_o = start_i & ~annul_i;
         S_SCAN:  stallreq_o = 1'b1;
         default: stallreq_o = 1'b0;
      endcase
   end

   assign ready_o     = (r_state == S_DONE);
   assign result_o    = {26'b0, r_result};
   assign dbg_state_o = r_state;

   // Datapath: CLO runs as CLZ on the inverted operand
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sh     <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (annul_i) begin
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_sh  <= op_i ? ~data_i : data_i;
                  r_cnt <= '0;
               end
            end
            S_SCAN: begin
               if (w_scan_end) begin
                  r_result <= r_cnt + w_lz;
               end else begin
                  r_cnt <= w_cnt_step;
                  r_sh  <= r_sh << STEP;
               end
            end
            S_DONE: if (!start_i) r_result <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_lead_count.sv
// Directed bench: three instances (STEP = 4, 1, 32) share one stimulus stream and
// are each checked for count, scan latency and stall behaviour.
module tb_ex_lead_count;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        op_i = 1'b0;
   logic [31:0] data_i = '0;
   logic        annul_i = 1'b0;

   logic [2:0]  rdy;
   logic [2:0]  stl;
   logic [31:0] res [3];
   logic [1:0]  st [3];
   int          steps [3] = '{4, 1, 32};

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ex_lead_count #(.STEP(4)) u_s4 (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .data_i(data_i),
      .annul_i(annul_i), .result_o(res[0]), .ready_o(rdy[0]),
      .stallreq_o(stl[0]), .dbg_state_o(st[0]));

   ex_lead_count #(.STEP(1)) u_s1 (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .data_i(data_i),
      .annul_i(annul_i), .result_o(res[1]), .ready_o(rdy[1]),
      .stallreq_o(stl[1]), .dbg_state_o(st[1]));

   ex_lead_count #(.STEP(32)) u_s32 (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .data_i(data_i),
      .annul_i(annul_i), .result_o(res[2]), .ready_o(rdy[2]),
      .stallreq_o(stl[2]), .dbg_state_o(st[2]));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input int n, input int s);
      int k;
      k = 1 + n / s;
      if (k > 32 / s) k = 32 / s;
      return k;
   endfunction

   task automatic check_idle(input string tag);
      for (int d = 0; d < 3; d++) begin
         check_val($sformatf("%s state s%0d", tag, steps[d]), 32'(st[d]), 32'd0);
         check_val($sformatf("%s ready s%0d", tag, steps[d]), 32'(rdy[d]), 32'd0);
         check_val($sformatf("%s result s%0d", tag, steps[d]), res[d], 32'd0);
         check_val($sformatf("%s stall s%0d", tag, steps[d]), 32'(stl[d]), 32'd0);
      end
   endtask

   // One op: accept, scan (operand scrambled after acceptance), hold in DONE, drop start.
   task automatic run_op(input logic op, input logic [31:0] val, input int n, input int hold);
      int lat [3];
      int stc [3];
      int cyc;
      @(negedge clk);
      start_i = 1'b1; op_i = op; data_i = val;
      #1;
      for (int d = 0; d < 3; d++) begin
         check_val($sformatf("accept stall s%0d", steps[d]), 32'(stl[d]), 32'd1);
         lat[d] = -1;
         stc[d] = 0;
      end
      cyc = 0;
      while (rdy != 3'b111 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            data_i = ~val; op_i = ~op;
         end
         for (int d = 0; d < 3; d++) begin
            if (stl[d]) stc[d]++;
            if (rdy[d] && lat[d] < 0) lat[d] = cyc;
         end
      end
      check_val("all ready", 32'(rdy), 32'd7);
      for (int d = 0; d < 3; d++) begin
         check_val($sformatf("op%0d %h result s%0d", op, val, steps[d]), res[d], 32'(n));
         check_val($sformatf("op%0d %h scan cycles s%0d", op, val, steps[d]),
                   32'(lat[d] - 1), 32'(exp_lat(n, steps[d])));
         check_val($sformatf("op%0d %h stall cycles s%0d", op, val, steps[d]),
                   32'(stc[d]), 32'(exp_lat(n, steps[d])));
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            check_val($sformatf("hold%0d result s%0d", h, steps[d]), res[d], 32'(n));
            check_val($sformatf("hold%0d ready s%0d", h, steps[d]), 32'(rdy[d]), 32'd1);
         end
      end
      start_i = 1'b0;
      @(negedge clk);
      check_idle("after drop");
   endtask

   initial begin
      logic [2:0] seen;
      // Reset
      #12;
      check_idle("reset");
      @(negedge clk);
      rst = 1'b1;

      run_op(1'b0, 32'h8000_0000, 0, 0);
      run_op(1'b0, 32'h0000_0001, 31, 0);
      run_op(1'b0, 32'h0000_0000, 32, 0);
      run_op(1'b1, 32'hFFF0_0000, 12, 3);
      run_op(1'b0, 32'h0000_F000, 16, 0);
      run_op(1'b1, 32'hFFFF_FFFF, 32, 0);
      run_op(1'b1, 32'h7FFF_FFFF, 0, 0);

      // Annul in the third scan cycle of CLZ 0
      @(negedge clk);
      start_i = 1'b1; op_i = 1'b0; data_i = 32'h0;
      seen = '0;
      repeat (2) begin
         @(negedge clk);
         seen |= rdy;
      end
      annul_i = 1'b1;
      @(negedge clk);
      check_val("annul ready seen s4", 32'(seen[0]), 32'd0);
      check_val("annul ready seen s1", 32'(seen[1]), 32'd0);
      check_idle("annul");
      annul_i = 1'b0; start_i = 1'b0;
      run_op(1'b0, 32'h0001_0000, 15, 0);

      // Asynchronous reset between clock edges, mid-scan
      @(negedge clk);
      start_i = 1'b1; op_i = 1'b0; data_i = 32'h0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0; start_i = 1'b0;
      #1;
      check_idle("async reset");
      @(negedge clk);
      rst = 1'b1;
      run_op(1'b0, 32'h4000_0000, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
